// File: rtl/biriscv_conv_unit_pkg.sv
// biriscv_conv_unit_pkg: conv instruction decode constants and FSM state encoding
package biriscv_conv_unit_pkg;
  localparam logic [6:0]  CONV_OPCODE       = 7'h0B;
  localparam logic [31:0] INST_CONV_F3_MASK = 32'h0000707f;
  localparam logic [31:0] INST_CONV_SETBASE = {17'd0, 3'd0, 5'd0, CONV_OPCODE};
  localparam logic [31:0] INST_CONV_SETSIZE = {17'd0, 3'd1, 5'd0, CONV_OPCODE};
  localparam logic [31:0] INST_CONV_RUN     = {17'd0, 3'd2, 5'd0, CONV_OPCODE};
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_IN,
    ST_WAIT_IN,
    ST_REQ_KER,
    ST_WAIT_KER,
    ST_MAC,
    ST_DONE
  } conv_state_e;
endpackage

// File: rtl/biriscv_conv_mac.sv
// biriscv_conv_mac: signed 32x32 multiply into a wrapping 32-bit accumulator with clear/enable
module biriscv_conv_mac (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] acc_o
);
  logic [31:0] acc_q, acc_d;
  always_comb acc_d = clr_i ? 32'd0 : en_i ? acc_q + 32'($signed(a_i) * $signed(b_i)) : acc_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) acc_q <= '0;
    else acc_q <= acc_d;
  end
  assign acc_o = acc_q;
endmodule

// File: rtl/biriscv_conv_unit.sv
// biriscv_conv_unit: conv custom-instruction exec unit; issue port in, single-outstanding mem read port, rd writeback and busy out
module biriscv_conv_unit
  import biriscv_conv_unit_pkg::*;
#(
  parameter int MAX_K  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              opcode_valid_i,
  input  logic [31:0]       opcode_opcode_i,
  input  logic [4:0]        opcode_rd_idx_i,
  input  logic [31:0]       opcode_ra_operand_i,
  input  logic [31:0]       opcode_rb_operand_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_accept_i,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_data_rd_i,
  input  logic              mem_error_i,
  output logic              writeback_valid_o,
  output logic [4:0]        writeback_idx_o,
  output logic [31:0]       writeback_value_o,
  output logic              writeback_error_o,
  output logic              busy_o
);
  localparam int KW = $clog2(MAX_K + 1);
  conv_state_e state_q, state_d;
  logic [ADDR_W-1:0] in_base_q, ker_base_q, in_ptr_q, ker_ptr_q;
  logic [KW-1:0] k_q, tap_q;
  logic [4:0] rd_q;
  logic [31:0] in_word_q, ker_word_q, acc;
  logic err_q, issue, set_base, set_size, run, ack_in, ack_ker, mac_en;
  assign issue    = opcode_valid_i && state_q == ST_IDLE;
  assign set_base = issue && (opcode_opcode_i & INST_CONV_F3_MASK) == INST_CONV_SETBASE;
  assign set_size = issue && (opcode_opcode_i & INST_CONV_F3_MASK) == INST_CONV_SETSIZE;
  assign run      = issue && (opcode_opcode_i & INST_CONV_F3_MASK) == INST_CONV_RUN;
  assign ack_in   = state_q == ST_WAIT_IN && mem_ack_i;
  assign ack_ker  = state_q == ST_WAIT_KER && mem_ack_i;
  assign mac_en   = state_q == ST_MAC;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     state_d = !run ? ST_IDLE : k_q == '0 ? ST_DONE : ST_REQ_IN;
      ST_REQ_IN:   state_d = mem_accept_i ? ST_WAIT_IN : ST_REQ_IN;
      ST_WAIT_IN:  state_d = !mem_ack_i ? ST_WAIT_IN : mem_error_i ? ST_DONE : ST_REQ_KER;
      ST_REQ_KER:  state_d = mem_accept_i ? ST_WAIT_KER : ST_REQ_KER;
      ST_WAIT_KER: state_d = !mem_ack_i ? ST_WAIT_KER : mem_error_i ? ST_DONE : ST_MAC;
      ST_MAC:      state_d = tap_q + KW'(1) == k_q ? ST_DONE : ST_REQ_IN;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      in_base_q  <= '0;
      ker_base_q <= '0;
      in_ptr_q   <= '0;
      ker_ptr_q  <= '0;
      k_q        <= '0;
      tap_q      <= '0;
      rd_q       <= '0;
      in_word_q  <= '0;
      ker_word_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_base) begin
        in_base_q  <= ADDR_W'(opcode_ra_operand_i & ~32'd3);
        ker_base_q <= ADDR_W'(opcode_rb_operand_i & ~32'd3);
      end
      if (set_size) k_q <= opcode_ra_operand_i > 32'(MAX_K) ? KW'(MAX_K) : KW'(opcode_ra_operand_i);
      if (run) begin
        rd_q      <= opcode_rd_idx_i;
        in_ptr_q  <= in_base_q + ADDR_W'(opcode_ra_operand_i << 2);
        ker_ptr_q <= ker_base_q;
        tap_q     <= '0;
        err_q     <= 1'b0;
      end
      if (ack_in) begin
        in_word_q <= mem_data_rd_i;
        err_q     <= mem_error_i;
      end
      if (ack_ker) begin
        ker_word_q <= mem_data_rd_i;
        err_q      <= mem_error_i;
      end
      if (mac_en) begin
        in_ptr_q  <= in_ptr_q + ADDR_W'(4);
        ker_ptr_q <= ker_ptr_q + ADDR_W'(4);
        tap_q     <= tap_q + KW'(1);
      end
    end
  end
  biriscv_conv_mac u_mac (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (run),
    .en_i  (mac_en),
    .a_i   (in_word_q),
    .b_i   (ker_word_q),
    .acc_o (acc)
  );
  assign busy_o            = state_q != ST_IDLE;
  assign mem_rd_o          = state_q == ST_REQ_IN || state_q == ST_REQ_KER;
  assign mem_addr_o        = state_q == ST_REQ_IN ? in_ptr_q : state_q == ST_REQ_KER ? ker_ptr_q : '0;
  assign writeback_valid_o = state_q == ST_DONE;
  assign writeback_idx_o   = writeback_valid_o ? rd_q : '0;
  assign writeback_error_o = writeback_valid_o && err_q;
  assign writeback_value_o = writeback_valid_o && !err_q ? acc : '0;
endmodule

// File: tb/tb_biriscv_conv_unit.sv
// tb_biriscv_conv_unit: randomized self-checking bench against a behavioural convolution model
module tb_biriscv_conv_unit;
  localparam int MAX_K = 16;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic opcode_valid_i = 1'b0;
  logic [31:0] opcode_opcode_i = '0;
  logic [4:0] opcode_rd_idx_i = '0;
  logic [31:0] opcode_ra_operand_i = '0;
  logic [31:0] opcode_rb_operand_i = '0;
  logic mem_rd_o;
  logic [31:0] mem_addr_o;
  logic mem_accept_i, mem_ack_i, mem_error_i;
  logic [31:0] mem_data_rd_i;
  logic writeback_valid_o, writeback_error_o, busy_o;
  logic [4:0] writeback_idx_o;
  logic [31:0] writeback_value_o;
  int checks = 0, errors = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] m_in_base = '0, m_ker_base = '0;
  int m_k = 0;
  logic run_active = 1'b0, wb_seen = 1'b0, wb_err = 1'b0, exp_err = 1'b0;
  logic [31:0] wb_val = '0, exp_val = '0;
  logic [4:0] exp_idx = '0;
  int exp_reads = 0, exp_lat = 0, cyc = 0, reads = 0, err_nth = 0, stall_cnt = 0;
  logic rand_acc = 1'b0, rand_ack = 1'b0;
  biriscv_conv_unit #(.MAX_K(MAX_K), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .opcode_valid_i(opcode_valid_i), .opcode_opcode_i(opcode_opcode_i), .opcode_rd_idx_i(opcode_rd_idx_i),
    .opcode_ra_operand_i(opcode_ra_operand_i), .opcode_rb_operand_i(opcode_rb_operand_i),
    .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_accept_i(mem_accept_i), .mem_ack_i(mem_ack_i),
    .mem_data_rd_i(mem_data_rd_i), .mem_error_i(mem_error_i),
    .writeback_valid_o(writeback_valid_o), .writeback_idx_o(writeback_idx_o),
    .writeback_value_o(writeback_value_o), .writeback_error_o(writeback_error_o), .busy_o(busy_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] memw(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction
  logic fire = 1'b0, held = 1'b0, pend = 1'b0;
  logic [31:0] faddr = '0, held_addr = '0, paddr = '0;
  int pdly = 0, pidx = 0;
  initial begin
    mem_accept_i = 1'b0;
    mem_ack_i = 1'b0;
    mem_error_i = 1'b0;
    mem_data_rd_i = '0;
    forever begin
      @(negedge clk_i);
      fire = mem_rd_o && mem_accept_i;
      faddr = mem_addr_o;
      if (mem_rd_o) begin
        chk("addr_align", {30'd0, mem_addr_o[1:0]}, 32'd0);
        chk("single_outstanding", {31'd0, pend}, 32'd0);
      end
      if (held) begin
        chk("rd_held", {31'd0, mem_rd_o}, 32'd1);
        chk("addr_held", mem_addr_o, held_addr);
      end
      held = mem_rd_o && !mem_accept_i;
      held_addr = mem_addr_o;
      if (fire) reads++;
      @(posedge clk_i);
      #1;
      mem_ack_i = 1'b0;
      mem_error_i = 1'b0;
      mem_data_rd_i = '0;
      if (rst_i) begin
        pend = 1'b0;
        held = 1'b0;
        fire = 1'b0;
      end
      if (fire) begin
        pend = 1'b1;
        paddr = faddr;
        pdly = rand_ack ? $urandom_range(0, 2) : 0;
        pidx = reads;
      end
      if (pend) begin
        if (pdly == 0) begin
          mem_ack_i = 1'b1;
          mem_data_rd_i = memw(paddr);
          mem_error_i = pidx == err_nth;
          pend = 1'b0;
        end else pdly--;
      end
      mem_accept_i = stall_cnt > 0 ? 1'b0 : rand_acc ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall_cnt > 0 && mem_rd_o) stall_cnt--;
    end
  end
  initial forever begin
    @(negedge clk_i);
    if (!run_active) begin
      chk("idle_busy", {31'd0, busy_o}, 32'd0);
      chk("idle_rd", {31'd0, mem_rd_o}, 32'd0);
      chk("idle_wb", {31'd0, writeback_valid_o}, 32'd0);
    end else if (!wb_seen) begin
      cyc++;
      chk("run_busy", {31'd0, busy_o}, 32'd1);
      if (writeback_valid_o) begin
        wb_seen = 1'b1;
        wb_val = writeback_value_o;
        wb_err = writeback_error_o;
        chk("wb_idx", {27'd0, writeback_idx_o}, {27'd0, exp_idx});
        chk("wb_value", writeback_value_o, exp_val);
        chk("wb_error", {31'd0, writeback_error_o}, {31'd0, exp_err});
        chk("wb_reads", reads, exp_reads);
        if (exp_lat != 0) chk("wb_latency", cyc, exp_lat);
      end
    end
  end
  task automatic do_reset();
    rst_i = 1'b1;
    run_active = 1'b0;
    m_in_base = '0;
    m_ker_base = '0;
    m_k = 0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask
  task automatic issue(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] ra, input logic [31:0] rb);
    opcode_valid_i = 1'b1;
    opcode_opcode_i = ($urandom() & ~32'h0000707f) | {17'd0, f3, 5'd0, 7'h0B};
    opcode_rd_idx_i = rd;
    opcode_ra_operand_i = ra;
    opcode_rb_operand_i = rb;
    @(posedge clk_i);
    #1;
    opcode_valid_i = 1'b0;
    opcode_opcode_i = $urandom();
    opcode_ra_operand_i = $urandom();
    opcode_rb_operand_i = $urandom();
  endtask
  task automatic setbase(input logic [31:0] ra, input logic [31:0] rb);
    issue(3'd0, 5'($urandom()), ra, rb);
    m_in_base = ra & ~32'd3;
    m_ker_base = rb & ~32'd3;
  endtask
  task automatic setsize(input logic [31:0] ra);
    issue(3'd1, 5'($urandom()), ra, $urandom());
    m_k = ra > 32'(MAX_K) ? MAX_K : int'(ra);
  endtask
  task automatic run(input logic [4:0] rd, input logic [31:0] ra, input int errn, input bit zw);
    int s;
    logic [31:0] a, b;
    s = 0;
    for (int k = 0; k < m_k; k++) begin
      a = memw(m_in_base + ((ra + 32'(k)) << 2));
      b = memw(m_ker_base + 32'(4 * k));
      s += $signed(a) * $signed(b);
    end
    exp_err = errn > 0 && errn <= 2 * m_k;
    exp_val = exp_err ? 32'd0 : 32'(s);
    exp_reads = exp_err ? errn : 2 * m_k;
    exp_idx = rd;
    exp_lat = zw && !exp_err && stall_cnt == 0 ? 5 * m_k + 1 : 0;
    err_nth = errn;
    rand_acc = !zw;
    rand_ack = !zw;
    reads = 0;
    cyc = 0;
    wb_seen = 1'b0;
    issue(3'd2, rd, ra, $urandom());
    run_active = 1'b1;
    for (int i = 0; i < 1500 && !wb_seen; i++) @(posedge clk_i);
    #1;
    run_active = 1'b0;
    if (!wb_seen) begin
      chk("wb_timeout", {31'd0, wb_seen}, 32'd1);
      do_reset();
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    mem[32'h1004] = 32'd2;
    mem[32'h1008] = -32'sd3;
    mem[32'h100C] = 32'd4;
    mem[32'h2000] = 32'd5;
    mem[32'h2004] = 32'd6;
    mem[32'h2008] = 32'd7;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_rd", {31'd0, mem_rd_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wb", {31'd0, writeback_valid_o}, 32'd0);
    chk("rst_value", writeback_value_o, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    setbase(32'h1000, 32'h2000);
    setsize(32'd3);
    run(5'd5, 32'd1, 0, 1'b1);
    chk("s1_value", wb_val, 32'h14);
    chk("s1_latency", cyc, 32'd16);
    stall_cnt = 4;
    run(5'd6, 32'd1, 0, 1'b1);
    chk("s4_value", wb_val, 32'h14);
    run(5'd8, 32'd1, 4, 1'b1);
    chk("s5_error", {31'd0, wb_err}, 32'd1);
    chk("s5_value", wb_val, 32'd0);
    chk("s5_reads", reads, 32'd4);
    setsize(32'd0);
    run(5'd7, 32'd9, 0, 1'b1);
    chk("s2_value", wb_val, 32'd0);
    chk("s2_latency", cyc, 32'd1);
    chk("s2_reads", reads, 32'd0);
    setsize(32'd40);
    run(5'd0, 32'd2, 0, 1'b0);
    chk("s3_reads", reads, 32'd32);
    setsize(32'd3);
    err_nth = 0;
    rand_acc = 1'b0;
    rand_ack = 1'b0;
    reads = 0;
    cyc = 0;
    wb_seen = 1'b0;
    exp_lat = 0;
    issue(3'd2, 5'd9, 32'd1, 32'd0);
    run_active = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    do_reset_mid();
    run(5'd3, $urandom(), 0, 1'b1);
    chk("s6_value", wb_val, 32'd0);
    chk("s6_reads", reads, 32'd0);
    for (int n = 0; n < 24; n++) begin
      if (n % 4 == 0) setbase(n % 8 == 0 ? 32'hFFFFFF00 + $urandom_range(0, 255) : $urandom(), $urandom());
      if (n % 3 == 0) setsize(n % 6 == 0 ? $urandom() : $urandom_range(0, 20));
      if ($urandom_range(0, 3) == 0) issue(3'($urandom_range(3, 7)), 5'($urandom()), 32'd1, 32'd2);
      run(5'($urandom()), $urandom_range(0, 3) == 0 ? $urandom() : $urandom_range(0, 64),
          $urandom_range(0, 3) == 0 ? $urandom_range(1, 8) : 0, 1'($urandom_range(0, 1)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  task automatic do_reset_mid();
    rst_i = 1'b1;
    run_active = 1'b0;
    #1;
    chk("mid_rst_rd", {31'd0, mem_rd_o}, 32'd0);
    chk("mid_rst_addr", mem_addr_o, 32'd0);
    chk("mid_rst_wb", {31'd0, writeback_valid_o}, 32'd0);
    chk("mid_rst_idx", {27'd0, writeback_idx_o}, 32'd0);
    chk("mid_rst_value", writeback_value_o, 32'd0);
    chk("mid_rst_error", {31'd0, writeback_error_o}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    m_in_base = '0;
    m_ker_base = '0;
    m_k = 0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask
endmodule

// File: doc/biriscv_conv_unit.md
Name: biriscv_conv_unit

Overview:
- Execution-side responder for the custom convolution instructions: CONV.SETBASE, CONV.SETSIZE and CONV.RUN.
- Sits in the issue/exec stage beside the mul and div units and receives an instruction whenever the decoder raises its conv issue flag.
- SETBASE and SETSIZE load configuration registers. RUN fetches a window of input words and kernel words over a single-outstanding memory read port, then multiply-accumulates them.
- The 32-bit result is written back to rd. busy_o stalls issue while a RUN is in progress.

Parameters:
- MAX_K, 16: maximum kernel length in taps. SETSIZE values above MAX_K are clamped to MAX_K.
- ADDR_W, 32: memory address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- opcode_valid_i  in  1  a conv instruction is issued this cycle
- opcode_opcode_i  in  32  instruction word
- opcode_rd_idx_i  in  5  destination register index
- opcode_ra_operand_i  in  32  rs1 value
- opcode_rb_operand_i  in  32  rs2 value
- mem_rd_o  out  1  read request
- mem_addr_o  out  ADDR_W  word address; bits [1:0] always 0
- mem_accept_i  in  1  request accepted
- mem_ack_i  in  1  read data valid
- mem_data_rd_i  in  32  read data
- mem_error_i  in  1  bus error, qualified by mem_ack_i
- writeback_valid_o  out  1  result valid, one-cycle pulse
- writeback_idx_o  out  5  rd of the completing RUN
- writeback_value_o  out  32  result
- writeback_error_o  out  1  RUN terminated by a bus error
- busy_o  out  1  unit occupied; issue stage must stall conv instructions

Behaviour:
- Encoding: opcode[6:0]=7'h0B (custom-0). Decode uses mask 32'h0000707f on funct3:
  - funct3=0: SETBASE. in_base<=ra&~3, ker_base<=rb&~3.
  - funct3=1: SETSIZE. K<=min(ra[4:0]... clamped value of ra, MAX_K); rb is ignored.
  - funct3=2: RUN rd, rs1. result = sum over k=0..K-1 of mem[in_base+4*(ra+k)] * mem[ker_base+4*k].
  - Other funct3 values are ignored with no side effect.
- Reset: every output is 0. in_base=0, ker_base=0, K=0, state=IDLE, accumulator=0.
- SETBASE and SETSIZE are accepted only in IDLE. They update the registers at the end of the issue cycle and produce no writeback.
- FSM:
  - IDLE --RUN--> if K==0 go to DONE with acc=0; otherwise go to REQ_IN.
  - REQ_IN: mem_rd_o=1, addr=in_ptr. Hold until mem_accept_i, then WAIT_IN.
  - WAIT_IN: on mem_ack_i latch the operand, then REQ_KER.
  - REQ_KER and WAIT_KER: same handshake on ker_ptr. On ack go to MAC.
  - MAC: acc<=acc+signed(in)*signed(ker), keeping the low 32 bits (wraps). Pointers advance by 4. tap count+1. If tap==K-1 go to DONE, else REQ_IN.
  - DONE: writeback_valid_o=1 for one cycle with the latched rd, then IDLE.
- Memory rules:
  - mem_addr_o and mem_rd_o are held stable until accept.
  - Only one request is outstanding at a time; the next request is not raised until the previous ack arrives.
  - Address arithmetic wraps modulo 2^ADDR_W.
- Latency with zero-wait memory (accept in the request cycle, ack the next cycle): 5 cycles per tap, plus 1 for DONE. K=3 gives writeback 16 cycles after issue. K=0 gives writeback 1 cycle after issue.
- busy_o=1 in every state except IDLE, including the DONE cycle. opcode_valid_i while busy is ignored; the issue stage must not do this.
- Bus error: mem_ack_i with mem_error_i aborts to DONE. writeback_error_o=1 and writeback_value_o=0.
- Reset asserted mid-RUN returns to IDLE immediately with no writeback. Configuration registers return to their reset values.
- rd=x0 still produces a writeback pulse with idx 0; the register file discards it.

Decomposition:
- Shared package / biriscv_defs.v holds:
  - INST_CONV_F3_MASK, INST_CONV_SETBASE, INST_CONV_SETSIZE, INST_CONV_RUN
  - the state encodings
  - CONV_OPCODE=7'h0B
- Sub-module biriscv_conv_mac: registered signed 32x32 multiply plus 32-bit accumulate, with clear and enable inputs. The top-level FSM and the memory handshake stay in biriscv_conv_unit.

Test Plan:
1. SETBASE(ra=0x1000, rb=0x2000); SETSIZE(ra=3); RUN rd=5, ra=1. Memory: in[0x1004..0x100C]={2,-3,4}, ker={5,6,7} -> writeback_valid_o pulse with idx=5 and value=0x00000014 (10-18+28=20) at cycle 16 with zero-wait memory.
2. SETSIZE(ra=0) then RUN rd=7 -> value 0 one cycle after issue, no mem_rd_o asserted.
3. SETSIZE(ra=40) with MAX_K=16 -> exactly 32 reads (16 input, 16 kernel) observed before writeback.
4. Hold mem_accept_i=0 for 4 cycles during REQ_IN -> mem_addr_o and mem_rd_o stable throughout; result unchanged from scenario 1.
5. Return mem_error_i on the second kernel read -> writeback_error_o=1, value=0, no further requests, busy_o drops the following cycle.
6. Assert rst_i during WAIT_KER -> all outputs 0 immediately, no writeback. A subsequent RUN uses base=0 and K=0 and returns 0.
